// File: rtl/sync_ram_pkg.sv
// Shared types and constants for the byte-lane synchronous RAM.
package sync_ram_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  localparam int unsigned DEF_WORD_W = 32;
  localparam int unsigned BE_W       = DEF_WORD_W / 8;

  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

  function automatic int unsigned be_lanes(input int unsigned word_w);
    return word_w / 8;
  endfunction

endpackage

// File: rtl/sync_ram_core.sv
// Storage array: byte-lane write port, registered read, read-during-write select.
module sync_ram_core
  import sync_ram_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned RDW_MODE = RDW_OLD
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [WORD_W/8-1:0]   be,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  localparam int unsigned LANES = be_lanes(WORD_W);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] old_word;
  logic [WORD_W-1:0] merged;

  assign old_word = mem[addr];

  always_comb begin
    merged = old_word;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= (RDW_MODE == RDW_NEW && we) ? merged : old_word;
  end

endmodule

// File: rtl/sync_ram_bw.sv
// Byte-lane single-port RAM with clear sweep, request gating and READ_LAT pipeline.
module sync_ram_bw
  import sync_ram_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 10,
  parameter int unsigned       DEPTH    = 1024,
  parameter int unsigned       WORD_W   = 32,
  parameter int unsigned       READ_LAT = 1,
  parameter int unsigned       RDW_MODE = RDW_OLD,
  parameter logic [WORD_W-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                cs,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [WORD_W/8-1:0] be,
  input  logic [WORD_W-1:0]   data_in,
  output logic [WORD_W-1:0]   data_out,
  output logic                rd_valid,
  output logic                busy,
  output logic                addr_err
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;

  logic in_range, acc, rd_acc;
  logic core_we, core_re;
  logic [ADDR_W-1:0]   core_addr;
  logic [WORD_W/8-1:0] core_be;
  logic [WORD_W-1:0]   core_wdata, rdata;

  logic              rd_v1, rd_zero1;
  logic [WORD_W-1:0] s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      CLEAR: begin
        if (ptr == ADDR_W'(DEPTH - 1)) begin
          state_nxt = READY;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      READY: begin
        if (clr) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  assign busy     = (state == CLEAR);
  assign in_range = {1'b0, addr} < (ADDR_W + 1)'(DEPTH);
  assign acc      = (state == READY) && cs && !clr;
  assign rd_acc   = acc && re;

  // The sweep borrows the single port; requests are never accepted while it runs.
  assign core_we    = busy || (acc && we && in_range);
  assign core_re    = rd_acc && in_range;
  assign core_addr  = busy ? ptr : addr;
  assign core_be    = busy ? '1 : be;
  assign core_wdata = busy ? INIT_VAL : data_in;

  sync_ram_core #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .WORD_W   (WORD_W),
    .RDW_MODE (RDW_MODE)
  ) u_core (
    .clk   (clk),
    .we    (core_we),
    .re    (core_re),
    .addr  (core_addr),
    .be    (core_be),
    .wdata (core_wdata),
    .rdata (rdata)
  );

  // The core register has no reset and skips out-of-range reads, so a
  // resettable flag masks it to zero in those cases instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1    <= 1'b0;
      rd_zero1 <= 1'b1;
      addr_err <= 1'b0;
    end else begin
      rd_v1    <= rd_acc;
      addr_err <= acc && (we || re) && !in_range;
      if (rd_acc) rd_zero1 <= !in_range;
    end
  end

  assign s1_data = rd_zero1 ? '0 : rdata;

  if (READ_LAT == 2) begin : g_lat2
    logic              v2;
    logic [WORD_W-1:0] out_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2    <= 1'b0;
        out_q <= '0;
      end else begin
        v2 <= rd_v1;
        if (rd_v1) out_q <= s1_data;
      end
    end

    assign rd_valid = v2;
    assign data_out = out_q;
  end else begin : g_lat1
    assign rd_valid = rd_v1;
    assign data_out = s1_data;
  end

endmodule

// File: tb/tb_sync_ram_bw.sv
// Two configurations of sync_ram_bw driven in parallel against a behavioural model.
module tb_sync_ram_bw;

  logic        clk = 1'b0;
  logic        rst_n, clr, cs, we, re;
  logic [9:0]  addr;
  logic [3:0]  be;
  logic [31:0] data_in;

  logic [31:0] data_out_a, data_out_b;
  logic        rd_valid_a, rd_valid_b, busy_a, busy_b, addr_err_a, addr_err_b;

  always #5 clk = ~clk;

  // a: DEPTH 1024, latency 1, read-first, clears to 0
  sync_ram_bw #(
    .ADDR_W(10), .DEPTH(1024), .WORD_W(32), .READ_LAT(1), .RDW_MODE(0), .INIT_VAL(32'h0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cs(cs), .we(we), .re(re), .addr(addr),
    .be(be), .data_in(data_in), .data_out(data_out_a), .rd_valid(rd_valid_a),
    .busy(busy_a), .addr_err(addr_err_a)
  );

  // b: DEPTH 1000, latency 2, write-first, clears to A5A5A5A5
  sync_ram_bw #(
    .ADDR_W(10), .DEPTH(1000), .WORD_W(32), .READ_LAT(2), .RDW_MODE(1), .INIT_VAL(32'hA5A5A5A5)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cs(cs), .we(we), .re(re), .addr(addr),
    .be(be), .data_in(data_in), .data_out(data_out_b), .rd_valid(rd_valid_b),
    .busy(busy_b), .addr_err(addr_err_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int m_depth(input int i);  return (i == 0) ? 1024 : 1000; endfunction
  function automatic int m_lat(input int i);    return (i == 0) ? 1 : 2;       endfunction
  function automatic bit m_newrd(input int i);  return (i == 1);               endfunction
  function automatic logic [31:0] m_init(input int i);
    return (i == 0) ? 32'h0 : 32'hA5A5A5A5;
  endfunction

  // model: memory words, sweep status, history of accepted reads by edge number
  logic [31:0] mem_m [2][1024];
  bit          m_busy [2];
  int          m_ptr  [2];
  bit          hv     [2][4];
  logic [31:0] hd     [2][4];
  bit          ev     [2];
  logic [31:0] edo    [2];
  bit          eerr   [2];
  int          cyc = 0;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int l = 0; l < 4; l++) if (b[l]) r[8*l +: 8] = n[8*l +: 8];
    return r;
  endfunction

  task automatic model_edge();
    bit acc, inr;
    int k;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] = 1'b1;
        m_ptr[i]  = 0;
        for (int s = 0; s < 4; s++) hv[i][s] = 1'b0;
        ev[i]   = 1'b0;
        edo[i]  = 32'h0;
        eerr[i] = 1'b0;
      end else begin
        acc = !m_busy[i] && cs && !clr;
        inr = int'(addr) < m_depth(i);
        hv[i][cyc % 4] = acc && re;
        hd[i][cyc % 4] = !inr ? 32'h0 :
                         (we && m_newrd(i)) ? merge(mem_m[i][addr], data_in, be) :
                         mem_m[i][addr];
        eerr[i] = acc && (we || re) && !inr;
        if (acc && we && inr) mem_m[i][addr] = merge(mem_m[i][addr], data_in, be);
        if (m_busy[i]) begin
          mem_m[i][m_ptr[i]] = m_init(i);
          if (m_ptr[i] == m_depth(i) - 1) m_busy[i] = 1'b0;
          else m_ptr[i]++;
        end else if (clr) begin
          m_busy[i] = 1'b1;
          m_ptr[i]  = 0;
        end
        k = (cyc + 5 - m_lat(i)) % 4;
        ev[i] = hv[i][k];
        if (ev[i]) edo[i] = hd[i][k];
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("busy_a", busy_a, m_busy[0]);
    chk("busy_b", busy_b, m_busy[1]);
    chk("rd_valid_a", rd_valid_a, ev[0]);
    chk("rd_valid_b", rd_valid_b, ev[1]);
    chk("data_out_a", data_out_a, edo[0]);
    chk("data_out_b", data_out_b, edo[1]);
    chk("addr_err_a", addr_err_a, eerr[0]);
    chk("addr_err_b", addr_err_b, eerr[1]);
  endtask

  task automatic drive(input logic c, input logic w, input logic r, input int a,
                       input logic [3:0] b, input logic [31:0] d);
    cs = c; we = w; re = r; addr = 10'(a); be = b; data_in = d; clr = 1'b0;
  endtask

  // counts sampled busy cycles of both instances until both are idle
  task automatic count_busy(output int ca, output int cb);
    ca = 0; cb = 0;
    for (int n = 0; n < 1200; n++) begin
      if (busy_a) ca++;
      if (busy_b) cb++;
      if (!busy_a && !busy_b) break;
      step();
    end
  endtask

  typedef struct {
    logic        w, r;
    int          a;
    logic [3:0]  b;
    logic [31:0] d;
    logic        va;
    logic [31:0] da;
    logic        vb;
    logic [31:0] db;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int ca, cb, first_b, nval_b, last_b;

    tbl[0] = '{1, 0, 3, 4'hF, 32'hAABBCCDD, 0, 32'h0,        0, 32'hA5A5A5A5};
    tbl[1] = '{1, 0, 3, 4'h5, 32'h11223344, 0, 32'h0,        0, 32'hA5A5A5A5};
    tbl[2] = '{0, 1, 3, 4'h0, 32'h0,        1, 32'hAA22CC44, 0, 32'hA5A5A5A5};
    tbl[3] = '{0, 0, 0, 4'h0, 32'h0,        0, 32'hAA22CC44, 1, 32'hAA22CC44};
    tbl[4] = '{1, 1, 7, 4'hF, 32'hDEADBEEF, 1, 32'h00000000, 0, 32'hAA22CC44};
    tbl[5] = '{0, 1, 7, 4'h0, 32'h0,        1, 32'hDEADBEEF, 1, 32'hDEADBEEF};
    tbl[6] = '{0, 1, 3, 4'h0, 32'h0,        1, 32'hAA22CC44, 1, 32'hDEADBEEF};
    tbl[7] = '{0, 0, 0, 4'h0, 32'h0,        0, 32'hAA22CC44, 1, 32'hAA22CC44};
    tbl[8] = '{0, 0, 0, 4'h0, 32'h0,        0, 32'hAA22CC44, 0, 32'hAA22CC44};

    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 1024; w++) mem_m[i][w] = 32'h0;

    // reset, then hold a read of address 5 through the initial sweep
    rst_n = 1'b0;
    drive(1, 0, 1, 5, 4'h0, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    count_busy(ca, cb);
    chk("init_sweep_len_a", ca, 1024);
    chk("init_sweep_len_b", cb, 1000);
    step();
    chk("first_read_valid_a", rd_valid_a, 1'b1);
    chk("first_read_data_a", data_out_a, 32'h0);
    drive(1, 0, 0, 0, 4'h0, 32'h0);
    for (int n = 0; n < 3; n++) step();

    // byte-lane merge and read-during-write vectors
    for (int i = 0; i < 9; i++) begin
      drive(1, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].d);
      step();
      chk("tbl_valid_a", rd_valid_a, tbl[i].va);
      chk("tbl_data_a", data_out_a, tbl[i].da);
      chk("tbl_valid_b", rd_valid_b, tbl[i].vb);
      chk("tbl_data_b", data_out_b, tbl[i].db);
    end

    // back-to-back reads of 0..15 after random writes
    for (int a = 0; a < 16; a++) begin
      drive(1, 1, 0, a, 4'($urandom), $urandom);
      step();
    end
    first_b = -1; nval_b = 0; last_b = -1;
    for (int j = 0; j < 19; j++) begin
      if (j < 16) drive(1, 0, 1, j, 4'h0, 32'h0);
      else drive(1, 0, 0, 0, 4'h0, 32'h0);
      step();
      if (rd_valid_b) begin
        if (first_b < 0) first_b = j;
        nval_b++;
        last_b = j;
      end
    end
    chk("burst_first_b", first_b, 1);
    chk("burst_count_b", nval_b, 16);
    chk("burst_last_b", last_b, 16);

    // out-of-range accesses on the 1000-word instance
    drive(1, 1, 0, 1000, 4'hF, 32'h12345678);
    step();
    chk("oor_wr_err_b", addr_err_b, 1'b1);
    chk("oor_wr_err_a", addr_err_a, 1'b0);
    drive(1, 0, 1, 1000, 4'h0, 32'h0);
    step();
    chk("oor_rd_err_b", addr_err_b, 1'b1);
    drive(1, 0, 1, 999, 4'h0, 32'h0);
    step();
    chk("oor_rd_valid_b", rd_valid_b, 1'b1);
    chk("oor_rd_data_b", data_out_b, 32'h0);
    drive(1, 0, 0, 0, 4'h0, 32'h0);
    step();
    chk("word999_b", data_out_b, mem_m[1][999]);

    // random traffic with occasional clears
    for (int n = 0; n < 600; n++) begin
      drive(($urandom % 8) != 0, $urandom % 2, $urandom % 2,
            ($urandom % 4 == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 31),
            4'($urandom), $urandom);
      clr = ($urandom % 150) == 0;
      step();
    end
    drive(1, 0, 0, 0, 4'h0, 32'h0);
    count_busy(ca, cb);

    // clear during traffic, then read back every word
    drive(1, 1, 1, 12, 4'hF, 32'h5A5A0000);
    step();
    drive(1, 1, 1, 13, 4'hF, 32'h0F0F0F0F);
    clr = 1'b1;
    step();
    drive(1, 0, 1, 14, 4'h0, 32'h0);
    count_busy(ca, cb);
    chk("clr_sweep_len_a", ca, 1024);
    chk("clr_sweep_len_b", cb, 1000);
    for (int a = 0; a < 1024; a++) begin
      drive(1, 0, 1, a, 4'h0, 32'h0);
      step();
    end
    drive(1, 0, 0, 0, 4'h0, 32'h0);
    step();
    step();
    chk("last_word_a", data_out_a, 32'h0);

    // reset in the middle of a sweep restarts it from the beginning
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int n = 0; n < 500; n++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    count_busy(ca, cb);
    chk("rst_sweep_len_a", ca, 1024);
    chk("rst_sweep_len_b", cb, 1000);
    drive(1, 0, 1, 500, 4'h0, 32'h0);
    step();
    step();
    chk("after_rst_b", data_out_b, 32'hA5A5A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
